// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types and defaults for the write-back port arbiter
package wb_port_arbiter_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned RD_W             = 5;
  localparam int unsigned DATA_W           = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } gnt_src_e;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_x0(input logic [RD_W-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - two-entry result buffer; storage is unreset, only pointers/count reset
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  wb_entry_t  push_data_i,
  input  logic       pop_i,
  output wb_entry_t  head_o,
  output logic [1:0] count_o
);

  wb_entry_t [1:0] mem_q, mem_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && (count_q != 2'd2);
    pop_ok   = pop_i && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between write-back and buffered
// multi-cycle results, with a starvation-triggered one-cycle forced drain
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wen_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [63:0] pipe_valD_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [63:0] mdu_data_i,
  output logic        mdu_ready_o,
  output logic        rf_wen_o,
  output logic [4:0]  rf_rd_o,
  output logic [63:0] rf_wdata_o,
  output logic        stall_o,
  output logic [1:0]  pend_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [3:0] starve_inc;
  gnt_src_e   gnt;
  wb_entry_t  head;
  wb_entry_t  push_entry;
  logic [1:0] cnt;
  logic [1:0] cnt_next;
  logic       pipe_req;
  logic       fifo_nonempty;
  logic       fifo_push;
  logic       fifo_pop;

  assign push_entry = '{rd: mdu_rd_i, data: mdu_data_i};

  wb_result_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .count_o     (cnt)
  );

  assign mdu_ready_o = (cnt < 2'd2);
  assign pend_cnt_o  = cnt;
  assign stall_o     = (state_q == ST_FORCE);

  // Pipe requests are masked while in reset so no write escapes during rst_n low.
  always_comb begin
    pipe_req      = rst_n && pipe_wen_i && !is_x0(pipe_rd_i);
    fifo_nonempty = (cnt != 2'd0);
    fifo_push     = mdu_valid_i && mdu_ready_o && !is_x0(mdu_rd_i);

    gnt = GNT_NONE;
    if (state_q == ST_FORCE) begin
      if (fifo_nonempty) gnt = GNT_FIFO;
    end else if (pipe_req) begin
      gnt = GNT_PIPE;
    end else if (fifo_nonempty) begin
      gnt = GNT_FIFO;
    end
    fifo_pop = (gnt == GNT_FIFO);

    cnt_next = cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
  end

  always_comb begin
    starve_inc = starve_q + 4'd1;
    starve_d   = 4'd0;
    state_d    = (cnt_next == 2'd0) ? ST_IDLE : ST_PEND;
    // The head lost this cycle: count it, and convert the limit-th loss into a drain.
    if (fifo_nonempty && !fifo_pop) begin
      if (starve_inc == LIMIT) begin
        state_d = ST_FORCE;
      end else begin
        starve_d = starve_inc;
      end
    end
  end

  always_comb begin
    rf_wen_o   = 1'b0;
    rf_rd_o    = '0;
    rf_wdata_o = '0;
    case (gnt)
      GNT_PIPE: begin
        rf_wen_o   = 1'b1;
        rf_rd_o    = pipe_rd_i;
        rf_wdata_o = pipe_valD_i;
      end
      GNT_FIFO: begin
        rf_wen_o   = 1'b1;
        rf_rd_o    = head.rd;
        rf_wdata_o = head.data;
      end
      default: begin
        rf_wen_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed bench with a queue-based reference model checked every cycle
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        pipe_wen_i;
  logic [4:0]  pipe_rd_i;
  logic [63:0] pipe_valD_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [63:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        rf_wen_o;
  logic [4:0]  rf_rd_o;
  logic [63:0] rf_wdata_o;
  logic        stall_o;
  logic [1:0]  pend_cnt_o;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_wen_i  (pipe_wen_i),
    .pipe_rd_i   (pipe_rd_i),
    .pipe_valD_i (pipe_valD_i),
    .mdu_valid_i (mdu_valid_i),
    .mdu_rd_i    (mdu_rd_i),
    .mdu_data_i  (mdu_data_i),
    .mdu_ready_o (mdu_ready_o),
    .rf_wen_o    (rf_wen_o),
    .rf_rd_o     (rf_rd_o),
    .rf_wdata_o  (rf_wdata_o),
    .stall_o     (stall_o),
    .pend_cnt_o  (pend_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue, losses counted per head.
  logic [68:0] mq[$];
  int          lose_cnt = 0;
  bit          force_now = 0;
  bit          m_pipe, m_pop, m_ready, m_wen, m_force_next;
  logic [4:0]  m_rd;
  logic [63:0] m_data;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        lose_cnt  = 0;
        force_now = 0;
        chk("model_rst_wen", rf_wen_o, 0);
        chk("model_rst_ready", mdu_ready_o, 1);
        chk("model_rst_pend", pend_cnt_o, 0);
        chk("model_rst_stall", stall_o, 0);
      end else begin
        m_ready = (mq.size() < 2);
        m_pipe  = pipe_wen_i && (pipe_rd_i != 0);
        m_pop   = 0;
        m_wen   = 0;
        m_rd    = 0;
        m_data  = 0;
        if (force_now) begin
          m_wen = 1; m_pop = 1; m_rd = mq[0][68:64]; m_data = mq[0][63:0];
        end else if (m_pipe) begin
          m_wen = 1; m_rd = pipe_rd_i; m_data = pipe_valD_i;
        end else if (mq.size() > 0) begin
          m_wen = 1; m_pop = 1; m_rd = mq[0][68:64]; m_data = mq[0][63:0];
        end
        chk("model_wen", rf_wen_o, m_wen);
        if (m_wen) begin
          chk("model_rd", rf_rd_o, m_rd);
          chk("model_data", rf_wdata_o, m_data);
        end
        chk("model_stall", stall_o, force_now);
        chk("model_pend", pend_cnt_o, mq.size());
        chk("model_ready", mdu_ready_o, m_ready);

        m_force_next = 0;
        if (m_pop) begin
          void'(mq.pop_front());
          lose_cnt = 0;
        end else if (mq.size() > 0) begin
          lose_cnt++;
          if (lose_cnt == LIMIT) begin
            m_force_next = 1;
            lose_cnt = 0;
          end
        end else begin
          lose_cnt = 0;
        end
        if (mdu_valid_i && m_ready && mdu_rd_i != 0) mq.push_back({mdu_rd_i, mdu_data_i});
        force_now = m_force_next;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input bit pw, input logic [4:0] prd, input logic [63:0] pd,
                       input bit mv, input logic [4:0] mrd, input logic [63:0] md);
    pipe_wen_i  = pw;
    pipe_rd_i   = prd;
    pipe_valD_i = pd;
    mdu_valid_i = mv;
    mdu_rd_i    = mrd;
    mdu_data_i  = md;
  endtask

  typedef struct {
    bit         pw;
    logic [4:0] prd;
    bit         mv;
    logic [4:0] mrd;
  } vec_t;

  vec_t vecs[12] = '{
    '{1, 5'd1,  1, 5'd2},  '{1, 5'd2,  1, 5'd3},  '{1, 5'd4,  1, 5'd6},
    '{1, 5'd5,  0, 5'd0},  '{1, 5'd6,  0, 5'd0},  '{1, 5'd7,  1, 5'd0},
    '{1, 5'd0,  1, 5'd9},  '{0, 5'd0,  1, 5'd12}, '{1, 5'd31, 0, 5'd0},
    '{1, 5'd30, 1, 5'd14}, '{1, 5'd29, 0, 5'd0},  '{0, 5'd0,  0, 5'd0}
  };

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 4, 64'h44);
    mid();
    chk("reset_wen", rf_wen_o, 0);
    chk("reset_ready", mdu_ready_o, 1);
    chk("reset_pend", pend_cnt_o, 0);
    chk("reset_stall", stall_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Lone MDU result
    drive(0, 0, 0, 1, 5, 64'hAB);
    mid(); chk("lone_no_bypass", rf_wen_o, 0);
    tick(); drive(0, 0, 0, 0, 0, 0);
    mid();
    chk("lone_wen", rf_wen_o, 1);
    chk("lone_rd", rf_rd_o, 5);
    chk("lone_data", rf_wdata_o, 64'hAB);
    chk("lone_pend1", pend_cnt_o, 1);
    tick(); mid();
    chk("lone_pend0", pend_cnt_o, 0);
    chk("lone_idle_wen", rf_wen_o, 0);

    // Priority and forced drain
    tick(); drive(1, 3, 64'h33, 1, 7, 64'h77);
    mid(); chk("prio_a_rd", rf_rd_o, 3);
    tick(); drive(1, 3, 64'h33, 1, 8, 64'h88);
    mid(); chk("prio_b_pend", pend_cnt_o, 1);
    tick(); drive(1, 3, 64'h33, 0, 0, 0);
    mid();
    chk("prio_c_pend", pend_cnt_o, 2);
    chk("prio_c_ready", mdu_ready_o, 0);
    chk("prio_c_stall", stall_o, 0);
    tick(); mid(); chk("prio_d_stall", stall_o, 0);
    tick(); mid(); chk("prio_e_stall", stall_o, 0); chk("prio_e_rd", rf_rd_o, 3);
    tick(); mid();
    chk("force_stall", stall_o, 1);
    chk("force_rd", rf_rd_o, 7);
    chk("force_data", rf_wdata_o, 64'h77);
    tick(); mid();
    chk("after_force_stall", stall_o, 0);
    chk("after_force_rd", rf_rd_o, 3);
    chk("after_force_pend", pend_cnt_o, 1);
    tick(); drive(0, 0, 0, 0, 0, 0);
    mid(); chk("drain8_rd", rf_rd_o, 8);
    tick(); mid(); chk("drain8_pend", pend_cnt_o, 0);

    // x0 handling
    tick(); drive(0, 0, 0, 1, 0, 64'h11);
    mid(); chk("x0_ready", mdu_ready_o, 1);
    tick(); drive(0, 0, 0, 0, 0, 0);
    mid(); chk("x0_pend", pend_cnt_o, 0); chk("x0_wen", rf_wen_o, 0);
    tick(); drive(0, 0, 0, 1, 9, 64'h99);
    mid(); chk("x0_push_wen", rf_wen_o, 0);
    tick(); drive(1, 0, 64'h55, 0, 0, 0);
    mid();
    chk("x0_pipe_wen", rf_wen_o, 1);
    chk("x0_pipe_rd", rf_rd_o, 9);
    chk("x0_pipe_data", rf_wdata_o, 64'h99);
    tick(); drive(0, 0, 0, 0, 0, 0);
    mid(); chk("x0_end_pend", pend_cnt_o, 0);

    // Push and pop together at count 1
    tick(); drive(0, 0, 0, 1, 10, 64'hA0);
    mid();
    tick(); drive(0, 0, 0, 1, 11, 64'hB0);
    mid();
    chk("pp_pend", pend_cnt_o, 1);
    chk("pp_rd", rf_rd_o, 10);
    chk("pp_data", rf_wdata_o, 64'hA0);
    tick(); drive(0, 0, 0, 0, 0, 0);
    mid();
    chk("pp_next_pend", pend_cnt_o, 1);
    chk("pp_next_rd", rf_rd_o, 11);
    chk("pp_next_data", rf_wdata_o, 64'hB0);
    tick(); mid(); chk("pp_end_pend", pend_cnt_o, 0);

    // Reset with two buffered entries
    tick(); drive(1, 3, 64'h33, 1, 12, 64'hC0);
    mid();
    tick(); drive(1, 3, 64'h33, 1, 13, 64'hD0);
    mid(); chk("rst2_pend1", pend_cnt_o, 1);
    tick(); drive(1, 3, 64'h33, 0, 0, 0);
    mid(); chk("rst2_pend2", pend_cnt_o, 2);
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst2_async_pend", pend_cnt_o, 0);
    chk("rst2_async_ready", mdu_ready_o, 1);
    mid();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("rst2_no_write", rf_wen_o, 0);
      chk("rst2_stay_empty", pend_cnt_o, 0);
      tick();
    end

    // Mixed vector table, checked by the model
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].pw, vecs[i].prd, 64'h1000 + 64'(i), vecs[i].mv, vecs[i].mrd, 64'h2000 + 64'(i));
      mid();
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (8) begin
      mid();
      tick();
    end
    mid();
    chk("final_pend", pend_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
